// File: rtl/seq_detect_pkg.sv
// Shared state encodings and default parameter values for the
// parameterised sequence detector.
package seq_detect_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'b00,
      HIT  = 2'b01,
      LOAD = 2'b10
   } state_t;

   localparam int         DEF_SYM_W     = 3;
   localparam int         DEF_SEQ_LEN   = 4;
   localparam int         DEF_CNT_W     = 8;
   localparam logic [11:0] DEF_RESET_PAT = 12'o0703;

endpackage

// File: rtl/seq_hist_cmp.sv
// Symbol history, saturating fill count and window-vs-pattern compare.
// The oldest symbol is never needed again once shifted, so only SEQ_LEN-1 are kept.
module seq_hist_cmp
   import seq_detect_pkg::*;
#(
   parameter int SYM_W   = DEF_SYM_W,
   parameter int SEQ_LEN = DEF_SEQ_LEN
) (
   input  logic                     clk,
   input  logic                     clear,
   input  logic                     i_shift,
   input  logic                     i_clr_fill,
   input  logic [SYM_W-1:0]         i_sym,
   input  logic [SYM_W*SEQ_LEN-1:0] i_pat,
   output logic                     o_cmp
);

   localparam int HW     = SYM_W * (SEQ_LEN - 1);
   localparam int FILL_W = $clog2(SEQ_LEN + 1);

   logic [HW-1:0]            r_hist;
   logic [FILL_W-1:0]        r_fill;
   logic [SYM_W*SEQ_LEN-1:0] w_window;

   // Newest symbol sits in the least-significant slot, matching the pattern layout.
   assign w_window = {r_hist, i_sym};
   assign o_cmp    = (r_fill >= FILL_W'(SEQ_LEN - 1)) && (w_window == i_pat);

   always_ff @(posedge clk) begin
      if (!clear) begin
         r_hist <= '0;
         r_fill <= '0;
      end else begin
         if (i_shift)
            r_hist <= w_window[HW-1:0];
         if (i_clr_fill)
            r_fill <= '0;
         else if (i_shift && (r_fill != FILL_W'(SEQ_LEN)))
            r_fill <= r_fill + 1'b1;
      end
   end

endmodule

// File: rtl/seq_detect_param.sv
// Programmable sequence detector: FSM, loadable pattern, saturating hit counter.
// Match is registered into the HIT state, so out is a pure Moore output.
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int                         SYM_W     = DEF_SYM_W,
   parameter int                         SEQ_LEN   = DEF_SEQ_LEN,
   parameter int                         CNT_W     = DEF_CNT_W,
   parameter logic [SYM_W*SEQ_LEN-1:0]   RESET_PAT = DEF_RESET_PAT
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [SYM_W-1:0] in,
   input  logic             in_valid,
   input  logic             overlap,
   input  logic             load,
   input  logic [SYM_W-1:0] load_sym,
   output logic             out,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] hit_cnt
);

   localparam int PTR_W = (SEQ_LEN > 2) ? $clog2(SEQ_LEN) : 1;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [SYM_W*SEQ_LEN-1:0] r_pat;
   logic [SYM_W*SEQ_LEN-1:0] w_pat_nxt;
   logic [PTR_W-1:0]         r_ptr;
   logic [PTR_W-1:0]         w_ptr_nxt;
   logic [PTR_W-1:0]         w_wr_idx;
   logic [CNT_W-1:0]         r_cnt;
   logic                     w_wr_en;
   logic                     w_clr_fill;
   logic                     w_accept;
   logic                     w_cmp;
   logic                     w_match;

   assign w_accept = in_valid && !load && (r_state != LOAD);
   assign w_match  = w_accept && w_cmp;

   seq_hist_cmp #(
      .SYM_W   (SYM_W),
      .SEQ_LEN (SEQ_LEN)
   ) u_hist (
      .clk        (clk),
      .clear      (clear),
      .i_shift    (w_accept),
      .i_clr_fill (w_clr_fill),
      .i_sym      (in),
      .i_pat      (r_pat),
      .o_cmp      (w_cmp)
   );

   always_ff @(posedge clk) begin
      if (!clear) begin
         r_state <= RUN;
         r_pat   <= RESET_PAT;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pat   <= w_pat_nxt;
         r_ptr   <= w_ptr_nxt;
         if (w_match && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_wr_en     = 1'b0;
      w_wr_idx    = '0;
      w_clr_fill  = 1'b0;
      case (r_state)
         RUN, HIT: begin
            if (load) begin
               w_wr_en     = 1'b1;
               w_ptr_nxt   = PTR_W'(1);
               w_clr_fill  = 1'b1;
               w_state_nxt = LOAD;
            end else if (w_match) begin
               w_clr_fill  = !overlap;
               w_state_nxt = HIT;
            end else begin
               w_state_nxt = RUN;
            end
         end
         LOAD: begin
            if (load) begin
               w_wr_en  = 1'b1;
               w_wr_idx = r_ptr;
               if (r_ptr == PTR_W'(SEQ_LEN - 1)) begin
                  w_ptr_nxt   = '0;
                  w_clr_fill  = 1'b1;
                  w_state_nxt = RUN;
               end else begin
                  w_ptr_nxt = r_ptr + 1'b1;
               end
            end
         end
         default: w_state_nxt = RUN;
      endcase
   end

   // Slot 0 is the first expected symbol and lives in the most-significant slot.
   always_comb begin
      w_pat_nxt = r_pat;
      for (int i = 0; i < SEQ_LEN; i++) begin
         if (w_wr_en && (w_wr_idx == PTR_W'(i)))
            w_pat_nxt[(SEQ_LEN-1-i)*SYM_W +: SYM_W] = load_sym;
      end
   end

   assign out     = (r_state == HIT);
   assign state   = r_state;
   assign hit_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed-vector bench for seq_detect_param: default build plus a
// SEQ_LEN=2 / CNT_W=2 build for back-to-back hits and counter saturation.
module tb_seq_detect_param;

   logic       clk = 1'b0;
   logic       clear;
   logic [2:0] aIn;
   logic       aValid;
   logic       aOverlap;
   logic       aLoad;
   logic [2:0] aLoadSym;
   logic       aOut;
   logic [1:0] aState;
   logic [7:0] aHitCnt;

   logic [2:0] bIn;
   logic       bValid;
   logic       bOut;
   logic [1:0] bState;
   logic [1:0] bHitCnt;

   int testCount = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   seq_detect_param dutA (
      .clk      (clk),
      .clear    (clear),
      .in       (aIn),
      .in_valid (aValid),
      .overlap  (aOverlap),
      .load     (aLoad),
      .load_sym (aLoadSym),
      .out      (aOut),
      .state    (aState),
      .hit_cnt  (aHitCnt)
   );

   seq_detect_param #(
      .SYM_W     (3),
      .SEQ_LEN   (2),
      .CNT_W     (2),
      .RESET_PAT (6'o00)
   ) dutB (
      .clk      (clk),
      .clear    (clear),
      .in       (bIn),
      .in_valid (bValid),
      .overlap  (1'b1),
      .load     (1'b0),
      .load_sym (3'd0),
      .out      (bOut),
      .state    (bState),
      .hit_cnt  (bHitCnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one edge of DUT A, then settle 1ns past the edge for sampling.
   task automatic applyStimulus(input logic v, input logic [2:0] s,
                                input logic ld, input logic [2:0] ls);
      aValid   = v;
      aIn      = s;
      aLoad    = ld;
      aLoadSym = ls;
      @(posedge clk);
      #1;
   endtask

   task automatic stepB(input logic v, input logic [2:0] s);
      bValid = v;
      bIn    = s;
      @(posedge clk);
      #1;
   endtask

   task automatic sendSym(input logic [2:0] s);
      applyStimulus(1'b1, s, 1'b0, 3'd0);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 3'd0, 1'b0, 3'd0);
   endtask

   initial begin
      clear    = 1'b0;
      aOverlap = 1'b1;
      bValid   = 1'b0;
      bIn      = 3'd0;
      applyStimulus(1'b1, 3'd5, 1'b1, 3'd5);
      applyStimulus(1'b0, 3'd0, 1'b0, 3'd0);
      checkOutput("reset_state", 32'(aState), 32'd0);
      checkOutput("reset_out", 32'(aOut), 32'd0);
      checkOutput("reset_cnt", 32'(aHitCnt), 32'd0);
      clear = 1'b1;

      // Basic 0,7,0,3 hit, high for exactly one cycle
      sendSym(3'd0); sendSym(3'd7); sendSym(3'd0);
      checkOutput("pre_hit_out", 32'(aOut), 32'd0);
      sendSym(3'd3);
      checkOutput("hit_out", 32'(aOut), 32'd1);
      checkOutput("hit_state", 32'(aState), 32'd1);
      checkOutput("hit_cnt1", 32'(aHitCnt), 32'd1);
      idle();
      checkOutput("hit_one_cycle_out", 32'(aOut), 32'd0);
      checkOutput("hit_one_cycle_state", 32'(aState), 32'd0);

      // Gaps in in_valid are transparent
      sendSym(3'd0); sendSym(3'd7);
      idle(); idle(); idle();
      sendSym(3'd0);
      checkOutput("gap_pre_out", 32'(aOut), 32'd0);
      sendSym(3'd3);
      checkOutput("gap_hit_out", 32'(aOut), 32'd1);
      checkOutput("gap_cnt", 32'(aHitCnt), 32'd2);

      // Wrong symbol breaks the match
      sendSym(3'd0); sendSym(3'd7); sendSym(3'd1); sendSym(3'd3);
      checkOutput("nomatch_out", 32'(aOut), 32'd0);
      checkOutput("nomatch_cnt", 32'(aHitCnt), 32'd2);

      // load wins over a completing symbol on the same edge
      sendSym(3'd0); sendSym(3'd7); sendSym(3'd0);
      applyStimulus(1'b1, 3'd3, 1'b1, 3'd7);
      checkOutput("ldprio_out", 32'(aOut), 32'd0);
      checkOutput("ldprio_state", 32'(aState), 32'd2);
      checkOutput("ldprio_cnt", 32'(aHitCnt), 32'd2);
      applyStimulus(1'b0, 3'd0, 1'b1, 3'd0);
      applyStimulus(1'b1, 3'd0, 1'b0, 3'd0);
      checkOutput("load_pause_state", 32'(aState), 32'd2);
      applyStimulus(1'b0, 3'd0, 1'b1, 3'd7);
      checkOutput("load_mid_state", 32'(aState), 32'd2);
      applyStimulus(1'b1, 3'd0, 1'b1, 3'd0);
      checkOutput("load_done_state", 32'(aState), 32'd0);
      checkOutput("load_done_cnt", 32'(aHitCnt), 32'd2);

      // Pattern 7,0,7,0 with overlap: hits after 4th and 6th symbols
      sendSym(3'd7); sendSym(3'd0); sendSym(3'd7);
      checkOutput("ov_pre_out", 32'(aOut), 32'd0);
      sendSym(3'd0);
      checkOutput("ov_hit4_out", 32'(aOut), 32'd1);
      sendSym(3'd7);
      checkOutput("ov_sym5_out", 32'(aOut), 32'd0);
      sendSym(3'd0);
      checkOutput("ov_hit6_out", 32'(aOut), 32'd1);
      checkOutput("ov_cnt", 32'(aHitCnt), 32'd4);

      // Same stream without overlap: only one hit
      aOverlap = 1'b0;
      sendSym(3'd1);
      sendSym(3'd7); sendSym(3'd0); sendSym(3'd7); sendSym(3'd0);
      checkOutput("nov_hit4_out", 32'(aOut), 32'd1);
      sendSym(3'd7); sendSym(3'd0);
      checkOutput("nov_sym6_out", 32'(aOut), 32'd0);
      checkOutput("nov_cnt", 32'(aHitCnt), 32'd5);

      // Reset during a load aborts it and restores 0,7,0,3
      aOverlap = 1'b1;
      applyStimulus(1'b0, 3'd0, 1'b1, 3'd1);
      applyStimulus(1'b0, 3'd0, 1'b1, 3'd2);
      checkOutput("abort_pre_state", 32'(aState), 32'd2);
      clear = 1'b0;
      applyStimulus(1'b1, 3'd3, 1'b1, 3'd4);
      checkOutput("abort_state", 32'(aState), 32'd0);
      checkOutput("abort_cnt", 32'(aHitCnt), 32'd0);
      clear = 1'b1;
      sendSym(3'd0); sendSym(3'd7); sendSym(3'd0); sendSym(3'd3);
      checkOutput("abort_rematch_out", 32'(aOut), 32'd1);
      checkOutput("abort_rematch_cnt", 32'(aHitCnt), 32'd1);
      idle();

      // SEQ_LEN=2 build: five 0s give four consecutive hits, counter sticks at 3
      stepB(1'b1, 3'd0);
      checkOutput("b_first_out", 32'(bOut), 32'd0);
      stepB(1'b1, 3'd0);
      checkOutput("b_hit2_out", 32'(bOut), 32'd1);
      checkOutput("b_hit2_cnt", 32'(bHitCnt), 32'd1);
      stepB(1'b1, 3'd0);
      checkOutput("b_hit3_out", 32'(bOut), 32'd1);
      stepB(1'b1, 3'd0);
      checkOutput("b_hit4_out", 32'(bOut), 32'd1);
      checkOutput("b_hit4_cnt", 32'(bHitCnt), 32'd3);
      stepB(1'b1, 3'd0);
      checkOutput("b_hit5_out", 32'(bOut), 32'd1);
      checkOutput("b_hit5_state", 32'(bState), 32'd1);
      checkOutput("b_sat_cnt", 32'(bHitCnt), 32'd3);
      stepB(1'b0, 3'd0);
      checkOutput("b_idle_out", 32'(bOut), 32'd0);
      checkOutput("b_idle_cnt", 32'(bHitCnt), 32'd3);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter SYM_W, default 3, symbol width in bits (>=1).
REQ-002 Parameter SEQ_LEN, default 4, pattern length in symbols (>=2).
REQ-003 Parameter CNT_W, default 8, hit counter width.
REQ-004 Parameter RESET_PAT, width SYM_W*SEQ_LEN, default 12'o0703 (symbols 0,7,0,3, first-expected symbol in most-significant slot), pattern loaded at reset.
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 clear  in  1  synchronous active-low reset.
REQ-008 in  in  SYM_W  input symbol.
REQ-009 in_valid  in  1  in is sampled this edge when 1.
REQ-010 overlap  in  1  1 = overlapping matches allowed, 0 = history discarded after a match.
REQ-011 load  in  1  write load_sym into the pattern at the current load pointer.
REQ-012 load_sym  in  SYM_W  pattern symbol being loaded.
REQ-013 out  out  1  Moore match flag, high exactly while state is HIT.
REQ-014 state  out  2  current FSM state: RUN=2'b00, HIT=2'b01, LOAD=2'b10.
REQ-015 hit_cnt  out  CNT_W  number of matches since reset, saturating.

Function
REQ-016 History: SEQ_LEN-symbol shift register plus fill count 0..SEQ_LEN (saturating), both advanced only on an accepted symbol.
REQ-017 A symbol is accepted on an edge with in_valid=1, load=0 and state not LOAD.
REQ-018 Match on an accepted symbol: fill >= SEQ_LEN-1 and the last SEQ_LEN-1 history symbols followed by in equal the pattern in order.
REQ-019 Latency: a match at edge k drives state=HIT and out=1 for the cycle after edge k; the comparison is never combinational to out.
REQ-020 RUN: match -> HIT; load=1 -> LOAD; otherwise stay RUN.
REQ-021 HIT: symbols are still accepted; a match -> HIT again (back-to-back hits give out high on consecutive cycles); load=1 -> LOAD; otherwise -> RUN.
REQ-022 overlap=1: after a match the history and fill are retained. overlap=0: fill is cleared to 0 on the matching edge.
REQ-023 hit_cnt increments by 1 on every match and holds at all-ones once saturated.
REQ-024 Load entry: load=1 in RUN or HIT writes load_sym to pattern slot 0, sets the pointer to 1, clears fill, ignores in_valid, and enters LOAD.
REQ-025 LOAD: load=1 writes slot[pointer] and increments the pointer; load=0 holds everything (pause); in_valid is ignored.
REQ-026 The write to slot SEQ_LEN-1 returns the FSM to RUN with the pointer at 0 and fill at 0.
REQ-027 load has priority over in_valid on the same edge; a match is not evaluated on that edge.
REQ-028 in_valid=0 edges neither shift nor clear history (gaps are transparent).

Reset
REQ-029 clear=0 at a rising edge: state RUN, out 0, hit_cnt 0, fill 0, history all-zero, pointer 0, pattern = RESET_PAT.
REQ-030 Reset overrides load and in_valid on the same edge; a reset during LOAD aborts the load and restores RESET_PAT.

Structure
REQ-031 Package seq_detect_pkg holds the state encodings (RUN, HIT, LOAD) and the default parameter values.
REQ-032 One sub-module, seq_hist_cmp (history shift register, fill count, pattern compare), instantiated once; the FSM, pattern registers, pointer and counter stay in the top level.

Verification (defaults unless stated)
REQ-033 Stream 0,7,0,3 on consecutive valid edges -> out=1 and state=01 for exactly the one cycle after the 3; hit_cnt=1.
REQ-034 Stream 0,7,{in_valid=0 x3},0,3 -> the match still occurs after the 3; stream 0,7,1,3 -> no match.
REQ-035 Load pattern 7,0,7,0, then stream 7,0,7,0,7,0 -> overlap=1 gives hit_cnt=2 (after the 4th and 6th symbols); overlap=0 gives hit_cnt=1.
REQ-036 SEQ_LEN=2, pattern 0,0, overlap=1, stream of five 0s -> out high on 4 consecutive cycles; with CNT_W=2, hit_cnt saturates at 3.
REQ-037 Load 1,2 then assert clear=0 before the load completes -> state=00, pattern reverts to 0,7,0,3 (0,7,0,3 matches again), hit_cnt=0.
REQ-038 load=1 and in_valid=1 with in=3 completing 0,7,0,3 on the same edge -> no hit, state=10, slot 0 written.
